// File: rtl/button_port_if.sv
// CPU-side bus shared with RAM: word address, write data and strobe out; select,
// read data and interrupt back from the peripheral.
interface button_port_if;
    logic [11:0] address;
    logic [15:0] data_out;
    logic        memwt;
    logic        sel;
    logic [15:0] rd_data;
    logic        irq;

    modport master (
        output address, data_out, memwt,
        input  sel, rd_data, irq
    );

    modport slave (
        input  address, data_out, memwt,
        output sel, rd_data, irq
    );
endinterface

// File: rtl/button_port.sv
// Memory-mapped pushbutton: synchroniser, debounce, press detection, sticky
// pending flag with irq, press counter and a four-word register window.
module button_port #(
    parameter logic [11:0] BASE_ADDR       = 12'h800,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          CNT_W           = 20,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pushbutton,
    button_port_if.slave  bus
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0]      ID_VALUE = 16'hB770;

    logic             btn;
    logic             sync1_reg;
    logic             sync2_reg;
    logic             debounced_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic             pending_reg;
    logic             edge_en_reg;
    logic [15:0]      press_count_reg;

    logic [11:0]      offset;
    logic             wr_status;
    logic             wr_count;
    logic             wr_control;
    logic             deb_done;
    logic             press;

    assign btn = pushbutton ^ ACTIVE_LOW;

    // Modular subtraction keeps the range test a single compare on the upper bits.
    assign offset  = bus.address - BASE_ADDR;
    assign bus.sel = (offset[11:2] == 10'd0);

    assign wr_status  = bus.memwt && bus.sel && (offset[1:0] == 2'd0);
    assign wr_count   = bus.memwt && bus.sel && (offset[1:0] == 2'd1);
    assign wr_control = bus.memwt && bus.sel && (offset[1:0] == 2'd2);

    assign deb_done = (sync2_reg != debounced_reg) && (deb_cnt_reg == DEB_LAST);
    assign press    = deb_done && sync2_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg     <= 1'b0;
            sync2_reg     <= 1'b0;
            debounced_reg <= 1'b0;
            deb_cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            if (sync2_reg == debounced_reg) begin
                deb_cnt_reg <= '0;
            end else if (deb_done) begin
                debounced_reg <= sync2_reg;
                deb_cnt_reg   <= '0;
            end else begin
                deb_cnt_reg <= deb_cnt_reg + 1'b1;
            end
        end
    end

    // A press in the same cycle as a clear or count write takes priority / adds on top.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg     <= 1'b0;
            edge_en_reg     <= 1'b0;
            press_count_reg <= 16'h0000;
        end else begin
            if (press && edge_en_reg)
                pending_reg <= 1'b1;
            else if (wr_status && bus.data_out[1])
                pending_reg <= 1'b0;

            if (wr_count)
                press_count_reg <= bus.data_out + {15'd0, press};
            else if (press)
                press_count_reg <= press_count_reg + 16'd1;

            if (wr_control)
                edge_en_reg <= bus.data_out[0];
        end
    end

    always_comb begin
        bus.rd_data = 16'h0000;
        if (bus.sel) begin
            case (offset[1:0])
                2'd0:    bus.rd_data = {14'd0, pending_reg, debounced_reg};
                2'd1:    bus.rd_data = press_count_reg;
                2'd2:    bus.rd_data = {15'd0, edge_en_reg};
                default: bus.rd_data = ID_VALUE;
            endcase
        end
    end

    assign bus.irq = pending_reg;
endmodule
